// File: rtl/ad9226_capture.sv
// ad9226_capture
//
// Multi-channel capture front end for AD9226-class parallel ADCs.
// The asynchronous ADC sample clock is synchronised into clk and its falling
// edge produces a one-cycle capture strobe. On each strobe every channel is
// accumulated; after 2^AVG_LOG2 samples the averaged frame is presented on a
// single-entry valid/ready output together with a frame sequence number.
// A completed frame that finds the output register still occupied is dropped
// and the sticky overrun flag is raised.
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   clk_sample    ADC sample clock, asynchronous to clk
//   enable        capture enable (level)
//   data_in       ADC data, channel 0 in the LSBs
//   m_data        averaged frame, channel 0 in the LSBs
//   m_valid       frame available
//   m_ready       downstream accepts the frame
//   m_seq         frame sequence number, wraps 255 -> 0
//   overrun       sticky, a completed frame was dropped
//   clear_overrun one-cycle pulse clearing overrun
module ad9226_capture #(
  parameter int ADC_DATA_WIDTH = 12,
  parameter int NUM_CH         = 4,
  parameter int AVG_LOG2       = 2,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clk_sample,
  input  logic                               enable,
  input  logic [NUM_CH*ADC_DATA_WIDTH-1:0]   data_in,
  output logic [NUM_CH*ADC_DATA_WIDTH-1:0]   m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [7:0]                         m_seq,
  output logic                               overrun,
  input  logic                               clear_overrun
);

  localparam int ACC_W = ADC_DATA_WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [0:0] {
    IDLE,
    ACC
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  logic                   cap;

  logic [ACC_W-1:0] acc      [NUM_CH];
  logic [ACC_W-1:0] acc_next [NUM_CH];
  logic [CNT_W-1:0] cnt;

  logic                             do_acc;
  logic                             clear_acc;
  logic                             frame_done;
  logic                             last_sample;
  logic                             drop;
  logic [NUM_CH*ADC_DATA_WIDTH-1:0] frame;

  // Synchroniser chain plus history flop. The strobe is registered so the
  // capture cycle lands SYNC_STAGES+1 clocks after the falling edge. The
  // history flop resets low, so a clk_sample that is already low when reset
  // releases never produces a spurious strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
      hist    <= 1'b0;
      cap     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], clk_sample};
      hist    <= sync_ff[SYNC_STAGES-1];
      cap     <= hist & ~sync_ff[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign last_sample = (cnt == CNT_LAST);

  // Dropping enable while accumulating clears the partial frame on the way
  // back to IDLE; a strobe in that same cycle is discarded with it.
  always_comb begin
    state_next = state;
    do_acc     = 1'b0;
    clear_acc  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        clear_acc = 1'b1;
        if (enable) begin
          state_next = ACC;
        end
      end
      ACC: begin
        if (!enable) begin
          state_next = IDLE;
          clear_acc  = 1'b1;
        end else if (cap) begin
          do_acc     = 1'b1;
          frame_done = last_sample;
        end
      end
      default: begin
        state_next = IDLE;
        clear_acc  = 1'b1;
      end
    endcase
  end

  // The frame includes the sample captured in the completing cycle, so it is
  // formed from the accumulator plus the current input. Dropping the low
  // AVG_LOG2 bits divides by the sample count with truncation.
  always_comb begin
    frame = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      acc_next[ch] = acc[ch] + ACC_W'(data_in[ch*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]);
      frame[ch*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] = acc_next[ch][ACC_W-1 -: ADC_DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= '0;
      end
    end else if (clear_acc || frame_done) begin
      cnt <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= '0;
      end
    end else if (do_acc) begin
      cnt <= cnt + CNT_W'(1);
      for (int ch = 0; ch < NUM_CH; ch++) begin
        acc[ch] <= acc_next[ch];
      end
    end
  end

  // A frame is dropped only when the output register is full and not being
  // emptied in the same cycle.
  assign drop = frame_done & m_valid & ~m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_seq   <= '0;
      overrun <= 1'b0;
    end else begin
      if (frame_done && (!m_valid || m_ready)) begin
        m_valid <= 1'b1;
        m_data  <= frame;
        m_seq   <= m_seq + 8'd1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ad9226_capture.sv
// tb_ad9226_capture
//
// Bench for ad9226_capture. Two instances run side by side: dut0 in
// pass-through (AVG_LOG2=0) and dut2 averaging four samples (AVG_LOG2=2).
// Every frame the bench expects is pushed to a per-instance queue when its
// stimulus is driven and popped when the instance hands it over.
module tb_ad9226_capture;

  localparam int W  = 12;
  localparam int NC = 4;
  localparam int DW = W * NC;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    seq;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cs0 = 1'b1, cs2 = 1'b1;
  logic          en0 = 1'b0, en2 = 1'b0;
  logic          rdy0 = 1'b0, rdy2 = 1'b0;
  logic          clr0 = 1'b0, clr2 = 1'b0;
  logic [DW-1:0] d0 = '0, d2 = '0;

  logic [DW-1:0] md0, md2;
  logic          mv0, mv2;
  logic [7:0]    sq0, sq2;
  logic          ov0, ov2;

  exp_t       q0[$];
  exp_t       q2[$];
  logic [7:0] seq0 = 8'd0;
  logic [7:0] seq2 = 8'd0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  ad9226_capture #(
    .ADC_DATA_WIDTH(W), .NUM_CH(NC), .AVG_LOG2(0), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clk_sample(cs0), .enable(en0), .data_in(d0),
    .m_data(md0), .m_valid(mv0), .m_ready(rdy0), .m_seq(sq0),
    .overrun(ov0), .clear_overrun(clr0)
  );

  ad9226_capture #(
    .ADC_DATA_WIDTH(W), .NUM_CH(NC), .AVG_LOG2(2), .SYNC_STAGES(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .clk_sample(cs2), .enable(en2), .data_in(d2),
    .m_data(md2), .m_valid(mv2), .m_ready(rdy2), .m_seq(sq2),
    .overrun(ov2), .clear_overrun(clr2)
  );

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference average of four samples per channel, truncated.
  function automatic logic [DW-1:0] avgFrame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [DW-1:0] c, input logic [DW-1:0] e);
    logic [DW-1:0] r;
    logic [W+1:0]  sum;
    r = '0;
    for (int ch = 0; ch < NC; ch++) begin
      sum = (W+2)'(a[ch*W +: W]) + (W+2)'(b[ch*W +: W]) + (W+2)'(c[ch*W +: W]) + (W+2)'(e[ch*W +: W]);
      r[ch*W +: W] = sum[W+1:2];
    end
    return r;
  endfunction

  task automatic pushExp(input int sel, input logic [DW-1:0] data);
    exp_t e;
    if (sel == 0) begin
      seq0   = seq0 + 8'd1;
      e.data = data;
      e.seq  = seq0;
      q0.push_back(e);
    end else begin
      seq2   = seq2 + 8'd1;
      e.data = data;
      e.seq  = seq2;
      q2.push_back(e);
    end
  endtask

  // Scoreboard: any handshake must match the oldest expected frame.
  task automatic checkOutput();
    exp_t e;
    if (mv0 && rdy0) begin
      checkValue("dut0 frame expected", 64'(q0.size() > 0), 64'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkValue("dut0 m_data", 64'(md0), 64'(e.data));
        checkValue("dut0 m_seq", 64'(sq0), 64'(e.seq));
      end
    end
    if (mv2 && rdy2) begin
      checkValue("dut2 frame expected", 64'(q2.size() > 0), 64'd1);
      if (q2.size() > 0) begin
        e = q2.pop_front();
        checkValue("dut2 m_data", 64'(md2), 64'(e.data));
        checkValue("dut2 m_seq", 64'(sq2), 64'(e.seq));
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
    end
  endtask

  // One clk_sample period: falling edge with data, low 6 clocks, high 4.
  task automatic applyStimulus(input int sel, input logic [DW-1:0] d);
    if (sel == 0) begin
      d0  = d;
      cs0 = 1'b0;
    end else begin
      d2  = d;
      cs2 = 1'b0;
    end
    steps(6);
    if (sel == 0) cs0 = 1'b1;
    else cs2 = 1'b1;
    steps(4);
  endtask

  initial begin
    logic [DW-1:0] av[4];
    logic [DW-1:0] pt;
    logic [DW-1:0] fa;
    logic [63:0]   r;

    // Reset values
    rst_n = 1'b0;
    steps(3);
    checkValue("reset m_valid0", 64'(mv0), 64'd0);
    checkValue("reset m_data0", 64'(md0), 64'd0);
    checkValue("reset m_seq0", 64'(sq0), 64'd0);
    checkValue("reset overrun0", 64'(ov0), 64'd0);
    checkValue("reset m_valid2", 64'(mv2), 64'd0);
    checkValue("reset m_seq2", 64'(sq2), 64'd0);
    rst_n = 1'b1;
    en0 = 1'b1; en2 = 1'b1; rdy0 = 1'b1; rdy2 = 1'b1;
    steps(5);

    // Pass-through with exact latency: valid 4 clocks after the falling edge
    pt = {12'hFFF, 12'h800, 12'h7FF, 12'h001};
    pushExp(0, pt);
    d0 = pt;
    cs0 = 1'b0;
    steps(3);
    checkValue("pt valid early", 64'(mv0), 64'd0);
    steps(1);
    checkValue("pt valid at latency", 64'(mv0), 64'd1);
    checkValue("pt seq", 64'(sq0), 64'd1);
    steps(1);
    checkValue("pt valid one cycle", 64'(mv0), 64'd0);
    steps(1);
    cs0 = 1'b1;
    steps(4);

    // Averaging and truncation on dut2
    av[0] = {12'h000, 12'h555, 12'h010, 12'hFFF};
    av[1] = {12'h000, 12'h555, 12'h020, 12'hFFF};
    av[2] = {12'h000, 12'h555, 12'h030, 12'hFFF};
    av[3] = {12'h003, 12'h555, 12'h040, 12'hFFE};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, av[i]);
      checkValue("avg no early frame", 64'(mv2), 64'd0);
    end
    pushExp(2, avgFrame(av[0], av[1], av[2], av[3]));
    applyStimulus(2, av[3]);
    av[0] = {12'h003, 12'h800, 12'hFFF, 12'h001};
    av[1] = {12'h003, 12'h800, 12'h000, 12'h002};
    av[2] = {12'h003, 12'h7FF, 12'h000, 12'h002};
    av[3] = {12'h003, 12'h7FF, 12'h000, 12'h002};
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, av[i]);
      checkValue("avg2 no early frame", 64'(mv2), 64'd0);
    end
    pushExp(2, avgFrame(av[0], av[1], av[2], av[3]));
    applyStimulus(2, av[3]);

    // Backpressure and overrun on dut0
    rdy0 = 1'b0;
    fa = {12'h123, 12'h456, 12'h789, 12'hABC};
    pushExp(0, fa);
    applyStimulus(0, fa);
    checkValue("bp valid", 64'(mv0), 64'd1);
    checkValue("bp seq", 64'(sq0), 64'(seq0));
    checkValue("bp no overrun yet", 64'(ov0), 64'd0);
    applyStimulus(0, {12'h111, 12'h222, 12'h333, 12'h444});
    checkValue("bp data held", 64'(md0), 64'(fa));
    checkValue("bp overrun set", 64'(ov0), 64'd1);
    applyStimulus(0, {12'h555, 12'h666, 12'h777, 12'h888});
    checkValue("bp data held 2", 64'(md0), 64'(fa));
    checkValue("bp seq held", 64'(sq0), 64'(seq0));
    checkValue("bp still valid", 64'(mv0), 64'd1);
    // Clear coinciding with a drop: the drop lands on the 4th clock
    d0 = {12'h999, 12'hAAA, 12'hBBB, 12'hCCC};
    cs0 = 1'b0;
    steps(3);
    clr0 = 1'b1;
    steps(1);
    clr0 = 1'b0;
    checkValue("ovr set wins", 64'(ov0), 64'd1);
    steps(2);
    cs0 = 1'b1;
    steps(4);
    clr0 = 1'b1;
    steps(1);
    clr0 = 1'b0;
    checkValue("ovr cleared", 64'(ov0), 64'd0);
    checkValue("bp data held 3", 64'(md0), 64'(fa));
    rdy0 = 1'b1;
    steps(2);
    checkValue("bp drained", 64'(mv0), 64'd0);

    // Enable abort on dut2: partial frame of 0xFFF must be discarded
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, {4{12'hFFF}});
    end
    checkValue("abort no frame", 64'(mv2), 64'd0);
    en2 = 1'b0;
    steps(2);
    en2 = 1'b1;
    steps(2);
    pushExp(2, {4{12'h100}});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, {4{12'h100}});
    end

    // Sequence wrap on dut0
    for (int i = 0; i < 256; i++) begin
      r = {$urandom(), $urandom()};
      pushExp(0, r[DW-1:0]);
      applyStimulus(0, r[DW-1:0]);
    end
    checkValue("seq after wrap", 64'(sq0), 64'(seq0));

    // Reset mid-frame with clk_sample low
    rdy0 = 1'b0;
    applyStimulus(0, {4{12'h0F0}});
    applyStimulus(0, {4{12'h0E0}});
    checkValue("pre-reset overrun", 64'(ov0), 64'd1);
    applyStimulus(2, {4{12'h777}});
    applyStimulus(2, {4{12'h777}});
    d2 = {4{12'hEEE}};
    cs2 = 1'b0;
    steps(6);
    #2;
    rst_n = 1'b0;
    cs0 = 1'b0;
    #1;
    checkValue("async m_valid0", 64'(mv0), 64'd0);
    checkValue("async m_data0", 64'(md0), 64'd0);
    checkValue("async m_seq0", 64'(sq0), 64'd0);
    checkValue("async overrun0", 64'(ov0), 64'd0);
    checkValue("async m_data2", 64'(md2), 64'd0);
    checkValue("async m_seq2", 64'(sq2), 64'd0);
    @(posedge clk);
    #1;
    steps(2);
    rst_n = 1'b1;
    seq0 = 8'd0;
    seq2 = 8'd0;
    rdy0 = 1'b1;
    steps(10);
    checkValue("no cap after release 0", 64'(mv0), 64'd0);
    checkValue("no cap after release 2", 64'(mv2), 64'd0);
    cs0 = 1'b1;
    cs2 = 1'b1;
    steps(4);
    pushExp(0, {12'h321, 12'h654, 12'h987, 12'hCBA});
    applyStimulus(0, {12'h321, 12'h654, 12'h987, 12'hCBA});
    av[0] = {4{12'h200}};
    av[1] = {4{12'h201}};
    av[2] = {4{12'h202}};
    av[3] = {4{12'h207}};
    pushExp(2, avgFrame(av[0], av[1], av[2], av[3]));
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2, av[i]);
    end
    steps(3);
    checkValue("dut0 frames outstanding", 64'(q0.size()), 64'd0);
    checkValue("dut2 frames outstanding", 64'(q2.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ad9226_capture.md
# ad9226_capture

Parametrised multi-channel capture front end for AD9226-class parallel ADCs. Synchronises the asynchronous ADC sample clock into `clk` and captures all channels on its falling edge. Optionally averages 2^AVG_LOG2 consecutive samples per channel, then presents each averaged frame on a single-entry valid/ready output with a sequence number and a sticky overrun flag. Sits between the ADC pin interface and the AXI-Stream packer.

## Interface
- ADC_DATA_WIDTH, 12: bits per channel sample, unsigned.
- NUM_CH, 4: number of ADC channels, 1..8.
- AVG_LOG2, 2: log2 of samples averaged per output frame, 0..4; 0 means pass-through.
- SYNC_STAGES, 2: synchroniser depth for clk_sample, 2..4.

- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- clk_sample  input  1  ADC sample clock, asynchronous to clk.
- enable  input  1  capture enable, level.
- data_in  input  NUM_CH*ADC_DATA_WIDTH  ADC data, channel 0 in LSBs.
- m_data  output  NUM_CH*ADC_DATA_WIDTH  averaged frame, channel 0 in LSBs.
- m_valid  output  1  frame available.
- m_ready  input  1  downstream accepts frame.
- m_seq  output  8  frame sequence number.
- overrun  output  1  sticky: a completed frame was dropped.
- clear_overrun  input  1  one-cycle pulse that clears overrun.

## Operation
- clk_sample passes through SYNC_STAGES flops plus one history flop. Falling edge = history 1, synced 0; this gives a one-cycle strobe `cap`.
- FSM states:
  - IDLE: entered on reset or when enable=0. Accumulators and sample counter are held at 0. Goes to ACC when enable=1.
  - ACC: on each `cap`, every channel accumulator adds its data_in slice, and the sample counter increments. When the counter reaches 2^AVG_LOG2-1 together with `cap`, that sample is included, a frame completes, and the counter and accumulators restart from 0 in the next cycle.
  - enable=0 in ACC: returns to IDLE on the next clk and discards the partial frame. m_valid and m_data are unaffected.
- Accumulator width is ADC_DATA_WIDTH+AVG_LOG2 and cannot overflow. Frame value = accumulator >> AVG_LOG2, truncated, no rounding.
- Output register, single entry:
  - On frame completion it loads if m_valid=0 or (m_valid&m_ready) in the same cycle.
  - On load, m_valid<=1, and m_seq increments (wraps 255->0).
  - Otherwise the frame is dropped, overrun<=1, and m_seq is not incremented.
- m_valid&m_ready with no new frame: m_valid<=0. m_data and m_seq hold their last values.
- m_data and m_seq are stable while m_valid=1 and m_ready=0.
- overrun is cleared by clear_overrun. If a drop and clear_overrun occur in the same cycle, set wins.
- Reset mid-operation: all state clears immediately. The first `cap` after release is not generated if clk_sample is already low, because the history flop resets to 0.

## Timing
- Reset values: m_valid=0, m_data=0, m_seq=0, overrun=0. FSM=IDLE, all accumulators and counters=0, synchroniser and history flops=0.
- `cap` asserts SYNC_STAGES+1 clk cycles after the clk_sample falling edge.
- data_in is sampled in the `cap` cycle. Integration must hold data_in stable from the falling edge for ≥ SYNC_STAGES+2 clk cycles.
- clk_sample high and low times must each be ≥ SYNC_STAGES+1 clk periods.
- m_valid rises on the clk after the `cap` that completes a frame. Total latency from the completing falling edge to m_valid is SYNC_STAGES+2 cycles.
- Throughput: one frame per 2^AVG_LOG2 clk_sample periods. m_ready may be held low for up to that interval without overrun.

## Test plan
- **Pass-through:** AVG_LOG2=0, NUM_CH=4, data_in ch0..3 = 0x001, 0x7FF, 0x800, 0xFFF, m_ready=1, one clk_sample falling edge -> after SYNC_STAGES+2 clks, m_valid=1 for one cycle with m_data equal to the inputs and m_seq=1.
- **Averaging/truncation:** AVG_LOG2=2, ch0 samples 0xFFF, 0xFFF, 0xFFF, 0xFFE -> one frame with ch0=0xFFF; samples 1, 2, 2, 2 -> ch0=1; no m_valid before the 4th edge.
- **Backpressure/overrun:** AVG_LOG2=0, m_ready=0 across 3 edges -> the first frame is held unchanged with m_seq=1; the 2nd and 3rd are dropped, overrun=1. Then clear_overrun pulse together with a drop -> overrun stays 1; a pulse alone -> overrun=0.
- **Enable abort:** AVG_LOG2=2, deassert enable after 3 samples, re-enable, apply 4 samples of 0x100 -> exactly one frame = 0x100; no frame contains the earlier partial data.
- **Sequence wrap and reset:** 256 frames with m_ready=1 -> m_seq goes 255 then 0. Assert rst_n=0 mid-frame with clk_sample low -> outputs return to reset values asynchronously, and no `cap` fires until the next high->low transition.
